// File: rtl/prefetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_unit_if
// Description : Bundles the instruction-memory request/response channel, the
//               decode-side instruction channel, the redirect input and the
//               performance counters of the prefetch unit.
//               master : prefetch unit side (issues fetches, feeds decode)
//               slave  : environment side (memory, decode, branch unit)
// Ports       : imem_req_valid/ready, imem_addr   - fetch request
//               imem_rsp_valid, imem_rsp_data     - in-order response beats
//               inst_valid/ready, inst_data/pc    - queue head toward decode
//               redirect_valid, redirect_pc       - branch/jump redirect
//               perf_fetched, perf_redirects      - event counters
// Revision    : 1.0 - initial release
// ============================================================================
interface prefetch_unit_if #(
  parameter int unsigned XLEN = 64
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_redirects;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready,
    input  redirect_valid, redirect_pc,
    output perf_fetched, perf_redirects
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready,
    output redirect_valid, redirect_pc,
    input  perf_fetched, perf_redirects
  );

endinterface
`default_nettype wire

// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_unit
// Description : Instruction prefetcher. Issues sequential word fetches, keeps
//               up to DEPTH instructions in a queue toward decode and never
//               has more requests in flight than free queue slots. A redirect
//               flushes the queue and drains stale responses in FLUSH.
// Ports       : clk   - sole clock, rising edge
//               reset - synchronous, active-high
//               bus   - prefetch_unit_if.master (memory, decode, redirect,
//                       performance counters)
// Config      : PREFETCH_PERF_EN - when defined, perf_fetched/perf_redirects
//               count delivered instructions and redirects; otherwise both
//               are tied to zero and no counter flops exist.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  prefetch_unit_if.master        bus
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;      // PC of the next fresh response
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     stale_q, stale_d;
  logic              req_valid_q, req_valid_d;
  logic              inst_valid_q, inst_valid_d;
  logic              settle_q;                 // first cycle after reset

  logic [31:0]       data_q [DEPTH];
  logic [XLEN-1:0]   pc_q   [DEPTH];

  logic              req_fire;
  logic              pop;
  logic              rsp;
  logic              push;
  logic [XLEN-1:0]   redir_pc;
  logic [CW-1:0]     inflight;

  assign req_fire = req_valid_q & bus.imem_req_ready;
  assign pop      = inst_valid_q & bus.inst_ready;
  // Responses still travelling from before reset are dropped for one cycle.
  assign rsp      = bus.imem_rsp_valid & ~settle_q;
  // A response coinciding with a redirect belongs to the old stream.
  assign push     = (state_q == ST_FETCH) & rsp & ~bus.redirect_valid;
  assign redir_pc = bus.redirect_pc & ~XLEN'(3);
  assign inflight = outstanding_q + CW'(req_fire);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q;
    stale_d       = stale_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      rsp_pc_d = rsp_pc_q + XLEN'(4);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case (state_q)
      ST_FETCH: begin
        if (bus.redirect_valid) begin
          // Everything in flight, including a request accepted this cycle,
          // becomes stale; a response arriving now retires one of them.
          stale_d       = (rsp && (inflight != '0)) ? inflight - CW'(1) : inflight;
          outstanding_d = '0;
          count_d       = '0;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          fetch_pc_d    = redir_pc;
          rsp_pc_d      = redir_pc;
          state_d       = (stale_d != '0) ? ST_FLUSH : ST_FETCH;
        end else begin
          outstanding_d = inflight - CW'(rsp);
        end
      end
      ST_FLUSH: begin
        if (rsp && (stale_q != '0)) begin
          stale_d = stale_q - CW'(1);
        end
        if (bus.redirect_valid) begin
          fetch_pc_d = redir_pc;
          rsp_pc_d   = redir_pc;
        end
        state_d = (stale_d == '0) ? ST_FETCH : ST_FLUSH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Outputs are registered from next-state values so they match the
    // occupancy/outstanding registers in the cycle they are presented.
    req_valid_d  = (state_d == ST_FETCH) &&
                   (({1'b0, count_d} + {1'b0, outstanding_d}) < {1'b0, DEPTH_C});
    inst_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      stale_q       <= '0;
      req_valid_q   <= 1'b0;
      inst_valid_q  <= 1'b0;
      settle_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      req_valid_q   <= req_valid_d;
      inst_valid_q  <= inst_valid_d;
      settle_q      <= 1'b0;
    end
  end

  // Queue storage carries no reset; contents are qualified by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= bus.imem_rsp_data;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_data      = data_q[rd_ptr_q];
  assign bus.inst_pc        = pc_q[rd_ptr_q];

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_redirects_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (bus.redirect_valid) begin
        perf_redirects_q <= perf_redirects_q + 32'd1;
      end
    end
  end

  assign bus.perf_fetched   = perf_fetched_q;
  assign bus.perf_redirects = perf_redirects_q;
`else
  assign bus.perf_fetched   = 32'd0;
  assign bus.perf_redirects = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_unit
// Description : Directed self-checking bench for prefetch_unit with an
//               in-order, fixed-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_unit;

  localparam logic [63:0] C_RESET_PC = 64'h1000;

  logic clk;
  logic reset;
  prefetch_unit_if #(.XLEN(64)) bus ();

  prefetch_unit #(
    .XLEN     (64),
    .DEPTH    (4),
    .RESET_PC (C_RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // ---------------- memory model and monitor ----------------
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [63:0] req_log[$];
  logic [63:0] dlv_pc[$];
  logic [31:0] dlv_data[$];
  int          edge_cnt = 0;
  int          lat = 1;
  logic        mem_clear = 1'b0;
  int          first_req_edge = -1;
  int          first_iv_edge = -1;
  int          coincide = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    int m;
    m = edge_cnt + 1;
    if (mem_clear) mq.delete();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= m) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    if (!reset && !mem_clear && bus.imem_req_valid && bus.imem_req_ready) begin
      mq.push_back('{addr: bus.imem_addr, due: m + lat});
      req_log.push_back(bus.imem_addr);
    end
    if (!reset && bus.imem_req_valid && first_req_edge < 0) first_req_edge = edge_cnt;
    if (!reset && bus.inst_valid && first_iv_edge < 0) first_iv_edge = edge_cnt;
    if (!reset && bus.inst_valid && bus.inst_ready) begin
      dlv_pc.push_back(bus.inst_pc);
      dlv_data.push_back(bus.inst_data);
      if (bus.redirect_valid && bus.imem_rsp_valid) coincide++;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    req_log.delete();
    dlv_pc.delete();
    dlv_data.delete();
    first_req_edge = -1;
    first_iv_edge  = -1;
    coincide       = 0;
  endtask

  task automatic do_reset(input int l, input logic rdy, input logic irdy);
    reset = 1'b1;
    mem_clear = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = rdy;
    bus.inst_ready     = irdy;
    lat = l;
    step();
    step();
    mem_clear = 1'b0;
    clear_logs();
    reset = 1'b0;
  endtask

  task automatic wait_dlv(input int n, input string tag);
    int budget = 200;
    while (dlv_pc.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (dlv_pc.size() < n) chk(tag, 64'(dlv_pc.size()), 64'(n));
  endtask

  task automatic wait_req(input int n, input string tag);
    int budget = 200;
    while (req_log.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (req_log.size() < n) chk(tag, 64'(req_log.size()), 64'(n));
  endtask

  task automatic redirect(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  logic [63:0] exp_perf_f;
  logic [63:0] exp_perf_r;

  initial begin
    int n0;
    int r0;
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int r0;
    reset = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // ---- reset state, first fetches and latency ----
    lat = 1;
    step();
    step();
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_req_valid",  64'(bus.imem_req_valid), 64'd0);
    chk("rst_perf_f",     64'(bus.perf_fetched), 64'd0);
    chk("rst_perf_r",     64'(bus.perf_redirects), 64'd0);
    clear_logs();
    reset = 1'b0;
    step();
    chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("first_addr",      bus.imem_addr, 64'h1000);
    wait_dlv(4, "seq_timeout");
    for (int i = 0; i < 3; i++) chk("seq_addr", req_log[i], 64'h1000 + 64'(4 * i));
    chk("first_latency", 64'(first_iv_edge - first_req_edge), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc",   dlv_pc[i], 64'h1000 + 64'(4 * i));
      chk("seq_data", 64'(dlv_data[i]), 64'(mem_word(64'h1000 + 64'(4 * i))));
    end

    // ---- queue fill with decode stalled ----
    do_reset(1, 1'b1, 1'b0);
    repeat (12) step();
    chk("fill_req_count", 64'(req_log.size()), 64'd4);
    chk("fill_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("fill_inst_valid", 64'(bus.inst_valid), 64'd1);
    bus.inst_ready = 1'b1;
    wait_dlv(4, "fill_timeout");
    for (int i = 0; i < 4; i++) begin
      chk("fill_pc",   dlv_pc[i], 64'h1000 + 64'(4 * i));
      chk("fill_data", 64'(dlv_data[i]), 64'(mem_word(64'h1000 + 64'(4 * i))));
    end

    // ---- redirect with three requests outstanding ----
    do_reset(5, 1'b1, 1'b1);
    wait_req(3, "flush_setup_timeout");
    bus.imem_req_ready = 1'b0;
    redirect(64'h2003);
    chk("flush_req_valid", 64'(bus.imem_req_valid), 64'd0);
    bus.imem_req_ready = 1'b1;
    wait_req(4, "flush_req_timeout");
    chk("flush_next_addr", req_log[3], 64'h2000);
    chk("flush_dropped",   64'(dlv_pc.size()), 64'd0);
    wait_dlv(1, "flush_dlv_timeout");
    chk("flush_next_pc",   dlv_pc[0], 64'h2000);
    chk("flush_next_data", 64'(dlv_data[0]), 64'(mem_word(64'h2000)));

    // ---- redirect with simultaneous response and pop ----
    do_reset(1, 1'b1, 1'b1);
    wait_dlv(3, "coin_setup_timeout");
    redirect(64'h3000);
    n0 = dlv_pc.size();
    chk("coin_event", 64'(coincide), 64'd1);
    chk("coin_popped_pc", dlv_pc[n0-1], 64'h1000 + 64'(4 * (n0 - 1)));
    wait_dlv(n0 + 1, "coin_timeout");
    chk("coin_next_pc", dlv_pc[n0], 64'h3000);
    bus.inst_ready = 1'b0;
    step();
`ifdef PREFETCH_PERF_EN
    exp_perf_f = 64'(dlv_pc.size());
    exp_perf_r = 64'd1;
`else
    exp_perf_f = 64'd0;
    exp_perf_r = 64'd0;
`endif
    chk("coin_perf_f", 64'(bus.perf_fetched), exp_perf_f);
    chk("coin_perf_r", 64'(bus.perf_redirects), exp_perf_r);

    // ---- address wrap at the top of the space ----
    do_reset(1, 1'b1, 1'b1);
    wait_dlv(1, "wrap_setup_timeout");
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    r0 = req_log.size();
    n0 = dlv_pc.size();
    wait_req(r0 + 2, "wrap_req_timeout");
    chk("wrap_addr0", req_log[r0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr1", req_log[r0+1], 64'h0);
    wait_dlv(n0 + 2, "wrap_dlv_timeout");
    chk("wrap_pc0", dlv_pc[n0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc1", dlv_pc[n0+1], 64'h0);

    // ---- redirect during FLUSH, then reset mid-FLUSH ----
    do_reset(5, 1'b1, 1'b1);
    wait_req(3, "rf_setup_timeout");
    bus.imem_req_ready = 1'b0;
    redirect(64'h4000);
    chk("rf_flush1_req_valid", 64'(bus.imem_req_valid), 64'd0);
    redirect(64'h4102);
    chk("rf_flush2_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rf_flush2_addr", bus.imem_addr, 64'h4100);
    reset = 1'b1;
    mem_clear = 1'b1;
    step();
    chk("rf_rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rf_rst_req_valid",  64'(bus.imem_req_valid), 64'd0);
    chk("rf_rst_addr",       bus.imem_addr, C_RESET_PC);
    chk("rf_rst_perf_f",     64'(bus.perf_fetched), 64'd0);
    chk("rf_rst_perf_r",     64'(bus.perf_redirects), 64'd0);
    mem_clear = 1'b0;
    clear_logs();
    reset = 1'b0;
    bus.imem_req_ready = 1'b1;
    step();
    chk("rf_restart_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("rf_restart_addr",      bus.imem_addr, C_RESET_PC);
    wait_dlv(1, "rf_dlv_timeout");
    chk("rf_restart_pc", dlv_pc[0], C_RESET_PC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
